// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: start bit, DATA_WIDTH data bits LSB first,
// optional even/odd parity and one or two stop bits, with a per-frame baud prescaler.
`timescale 1ns/1ps
module uart_tx_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  DATA_READY,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [PRESC_W-1:0]    PRESCALE,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  FRAME_DONE
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic parity_f(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return odd ? ~^d : ^d;
  endfunction

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   sh_q;
  logic [BIT_W-1:0]        bit_q;
  logic                    par_bit_q;
  logic                    par_en_q;
  logic                    stop2_q;
  logic                    stop_idx_q;
  logic [PRESC_W-1:0]      presc_m1_q;
  logic [PRESC_W-1:0]      cnt_q;
  logic                    tx_q;
  logic                    busy_q;
  logic                    ready_q;
  logic                    done_q;

  logic                    accept_s;
  logic                    final_stop_s;
  logic                    one_cyc_bit_s;
  logic [PRESC_W-1:0]      presc_m1_s;

  // Handshake and timing helpers; a PRESCALE of zero behaves like one.
  always_comb begin
    accept_s      = ready_q & DATA_VALID;
    final_stop_s  = (state_q == ST_STOP) && (stop_idx_q == stop2_q);
    one_cyc_bit_s = (presc_m1_q == {PRESC_W{1'b0}});
    if (PRESCALE == {PRESC_W{1'b0}}) begin
      presc_m1_s = {PRESC_W{1'b0}};
    end else begin
      presc_m1_s = PRESCALE - {{(PRESC_W-1){1'b0}}, 1'b1};
    end
  end

  // Frame sequencer; all outputs are registered to reflect the state of the following cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      sh_q       <= {DATA_WIDTH{1'b0}};
      bit_q      <= {BIT_W{1'b0}};
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      presc_m1_q <= {PRESC_W{1'b0}};
      cnt_q      <= {PRESC_W{1'b0}};
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
    end else if (accept_s) begin
      state_q    <= ST_START;
      sh_q       <= P_DATA;
      bit_q      <= {BIT_W{1'b0}};
      par_bit_q  <= parity_f(P_DATA, PAR_TYP);
      par_en_q   <= PAR_EN;
      stop2_q    <= STOP2;
      stop_idx_q <= 1'b0;
      presc_m1_q <= presc_m1_s;
      cnt_q      <= presc_m1_s;
      tx_q       <= 1'b0;
      busy_q     <= 1'b1;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
    end else if (state_q != ST_IDLE && cnt_q != {PRESC_W{1'b0}}) begin
      // Mid-bit: hold the line, flag the last cycle of the final stop bit one cycle ahead.
      cnt_q   <= cnt_q - {{(PRESC_W-1){1'b0}}, 1'b1};
      ready_q <= final_stop_s && (cnt_q == {{(PRESC_W-1){1'b0}}, 1'b1});
      done_q  <= final_stop_s && (cnt_q == {{(PRESC_W-1){1'b0}}, 1'b1});
    end else begin
      cnt_q   <= presc_m1_q;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        ST_START: begin
          state_q <= ST_DATA;
          bit_q   <= {BIT_W{1'b0}};
          tx_q    <= sh_q[0];
        end
        ST_DATA: begin
          if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
            stop_idx_q <= 1'b0;
            if (par_en_q) begin
              state_q <= ST_PARITY;
              tx_q    <= par_bit_q;
            end else begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
              ready_q <= one_cyc_bit_s && !stop2_q;
              done_q  <= one_cyc_bit_s && !stop2_q;
            end
          end else begin
            bit_q <= bit_q + {{(BIT_W-1){1'b0}}, 1'b1};
            sh_q  <= sh_q >> 1;
            tx_q  <= sh_q[1];
          end
        end
        ST_PARITY: begin
          state_q    <= ST_STOP;
          stop_idx_q <= 1'b0;
          tx_q       <= 1'b1;
          ready_q    <= one_cyc_bit_s && !stop2_q;
          done_q     <= one_cyc_bit_s && !stop2_q;
        end
        ST_STOP: begin
          if (!final_stop_s) begin
            stop_idx_q <= 1'b1;
            tx_q       <= 1'b1;
            ready_q    <= one_cyc_bit_s;
            done_q     <= one_cyc_bit_s;
          end else begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign TX_OUT     = tx_q;
  assign Busy       = busy_q;
  assign DATA_READY = ready_q;
  assign FRAME_DONE = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: hand-computed frame waveforms checked every cycle.
`timescale 1ns/1ps
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        RST;
  logic [7:0]  P_DATA;
  logic        DATA_VALID;
  logic        DATA_READY;
  logic        PAR_EN;
  logic        PAR_TYP;
  logic        STOP2;
  logic [15:0] PRESCALE;
  logic        TX_OUT;
  logic        Busy;
  logic        FRAME_DONE;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  uart_tx_cfg #(.DATA_WIDTH(8), .PRESC_W(16)) dut (
    .CLK(clk), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .DATA_READY(DATA_READY), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .PRESCALE(PRESCALE), .TX_OUT(TX_OUT), .Busy(Busy), .FRAME_DONE(FRAME_DONE)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a word and hold DATA_VALID across one rising edge; returns at the negedge of frame cycle 1.
  task automatic send(input logic [7:0] d, input logic pen, input logic ptyp,
                      input logic s2, input logic [15:0] p);
    P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; STOP2 = s2; PRESCALE = p;
    DATA_VALID = 1'b1;
    @(negedge clk);
    DATA_VALID = 1'b0;
  endtask

  // bits[i] is the i-th serial bit; each bit is expected for p cycles.
  task automatic frame_check(input string tag, input logic [11:0] bits, input int nbits, input int p);
    for (int i = 0; i < nbits; i++) begin
      for (int j = 0; j < p; j++) begin
        automatic logic last = (i == nbits - 1) && (j == p - 1);
        check({tag, " tx"},    {31'd0, TX_OUT},     {31'd0, bits[i]});
        check({tag, " busy"},  {31'd0, Busy},       32'd1);
        check({tag, " done"},  {31'd0, FRAME_DONE}, {31'd0, last});
        check({tag, " ready"}, {31'd0, DATA_READY}, {31'd0, last});
        @(negedge clk);
      end
    end
  endtask

  task automatic idle_check(input string tag);
    check({tag, " idle tx"},    {31'd0, TX_OUT},     32'd1);
    check({tag, " idle busy"},  {31'd0, Busy},       32'd0);
    check({tag, " idle ready"}, {31'd0, DATA_READY}, 32'd1);
    check({tag, " idle done"},  {31'd0, FRAME_DONE}, 32'd0);
  endtask

  initial begin
    RST = 1'b1; DATA_VALID = 1'b0; P_DATA = 8'h00;
    PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; PRESCALE = 16'd1;
    repeat (2) @(negedge clk);
    check("rst tx",    {31'd0, TX_OUT},     32'd1);
    check("rst busy",  {31'd0, Busy},       32'd0);
    check("rst ready", {31'd0, DATA_READY}, 32'd0);
    check("rst done",  {31'd0, FRAME_DONE}, 32'd0);
    RST = 1'b0;
    @(negedge clk);
    idle_check("post rst");

    // 0xCB even parity: 0,1,1,0,1,0,0,1,1,1,1
    send(8'hCB, 1'b1, 1'b0, 1'b0, 16'd1);
    frame_check("t1", 12'h796, 11, 1);
    idle_check("t1");

    // 0xCB odd parity: parity bit 0
    send(8'hCB, 1'b1, 1'b1, 1'b0, 16'd1);
    frame_check("t2", 12'h596, 11, 1);
    idle_check("t2");

    // no parity, two stop bits, 4 cycles per bit
    send(8'hCB, 1'b0, 1'b0, 1'b1, 16'd4);
    frame_check("t3", 12'h796, 11, 4);
    idle_check("t3");

    // back-to-back: 0x35 held valid during the first frame
    send(8'hCB, 1'b0, 1'b0, 1'b0, 16'd1);
    P_DATA = 8'h35; DATA_VALID = 1'b1;
    frame_check("t4a", 12'h396, 10, 1);
    DATA_VALID = 1'b0;
    frame_check("t4b", 12'h26A, 10, 1);
    idle_check("t4");

    // reset during data bit 3 (frame cycle 5)
    send(8'hCB, 1'b0, 1'b0, 1'b0, 16'd1);
    repeat (4) @(negedge clk);
    check("t5 bit3 tx",   {31'd0, TX_OUT}, 32'd1);
    check("t5 bit3 busy", {31'd0, Busy},   32'd1);
    RST = 1'b1;
    @(negedge clk);
    check("t5 rst tx",    {31'd0, TX_OUT},     32'd1);
    check("t5 rst busy",  {31'd0, Busy},       32'd0);
    check("t5 rst ready", {31'd0, DATA_READY}, 32'd0);
    check("t5 rst done",  {31'd0, FRAME_DONE}, 32'd0);
    RST = 1'b0;
    @(negedge clk);
    idle_check("t5 release");

    // PRESCALE=0 behaves as 1; config changed mid-frame must not affect it
    send(8'hCB, 1'b1, 1'b0, 1'b0, 16'd0);
    PAR_EN = 1'b0; PAR_TYP = 1'b1; STOP2 = 1'b1; PRESCALE = 16'd5;
    frame_check("t6", 12'h796, 11, 1);
    idle_check("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
